// File: rtl/musa_trace_capture.sv
// Trace buffer for the MUSA core: captures per-cycle instruction/control snapshots around a
// masked-compare trigger, then streams them out oldest-first. Define MUSA_TRACE_FILTER_EN to add filter_mask.
module musa_trace_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 12,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   instr,
  input  logic [CTRL_WIDTH-1:0]   ctrl,
  input  logic [DATA_WIDTH-1:0]   trig_mask,
  input  logic [DATA_WIDTH-1:0]   trig_value,
`ifdef MUSA_TRACE_FILTER_EN
  input  logic [CTRL_WIDTH-1:0]   filter_mask,
`endif
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_instr,
  output logic [CTRL_WIDTH-1:0]   rd_ctrl,
  output logic [TS_WIDTH-1:0]     rd_ts,
  output logic                    rd_last,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [TS_WIDTH-1:0]   ts;
  } entry_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_d;
  logic [PW-1:0]       post_q, post_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  entry_t              rd_entry_q, rd_entry_d;
  entry_t              ram_q [DEPTH];
  entry_t              wr_entry;

  logic capturing;
  logic trig_hit;
  logic filter_pass;
  logic store_en;
  logic rd_fire;

  assign capturing = (state_q == ARMED) || (state_q == POST);
  assign trig_hit  = (state_q == ARMED) && sample_valid &&
                     ((instr & trig_mask) == (trig_value & trig_mask));

`ifdef MUSA_TRACE_FILTER_EN
  assign filter_pass = (filter_mask == '0) || ((ctrl & filter_mask) != '0);
`else
  assign filter_pass = 1'b1;
`endif

  // The trigger sample bypasses the filter so the capture always contains its own cause.
  assign store_en = capturing && sample_valid && !arm && (filter_pass || trig_hit);
  assign rd_fire  = rd_valid_q && rd_ready;
  assign wr_entry = '{instr: instr, ctrl: ctrl, ts: ts_q};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    post_d     = post_q;
    ts_d       = ts_q;
    rd_entry_d = rd_entry_q;

    if (arm) begin
      state_d  = ARMED;
      count_d  = '0;
      wr_ptr_d = '0;
      post_d   = '0;
      ts_d     = '0;
    end else begin
      unique case (state_q)
        ARMED, POST: begin
          ts_d = ts_q + 1'b1;
          if (store_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
          end
          if (trig_hit) begin
            if (POST_TRIG == 0) begin
              state_d = DONE;
            end else begin
              state_d = POST;
              post_d  = PW'(POST_TRIG);
            end
          end else if ((state_q == POST) && store_en) begin
            post_d = post_q - 1'b1;
            if (post_q == PW'(1)) state_d = DONE;
          end
        end
        DONE: begin
          if (rd_fire) begin
            count_d = count_q - 1'b1;
            if (rd_last_q) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Readout registers track the entry that will be oldest after this edge.
    rd_valid_d = (state_d == DONE) && (count_d != '0);
    rd_last_d  = rd_valid_d && (count_d == CW'(1));
    rd_ptr_d   = wr_ptr_d - count_d[PW-1:0];
    if (rd_valid_d) begin
      rd_entry_d = (store_en && (rd_ptr_d == wr_ptr_q)) ? wr_entry : ram_q[rd_ptr_d];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      post_q     <= '0;
      ts_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      post_q     <= post_d;
      ts_q       <= ts_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  // NOTE: the RAM is deliberately not reset; count gates every read, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (store_en) ram_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_instr = rd_entry_q.instr;
  assign rd_ctrl  = rd_entry_q.ctrl;
  assign rd_ts    = rd_entry_q.ts;
  assign state    = state_q;
  assign count    = count_q;

endmodule
